// File: rtl/i2c_slave.sv
`timescale 1ns/1ps
// i2c_slave: oversampled I2C target with 7-bit address match and a
// byte-level rx/tx handshake. SDA is open-drain (driven 0 or Z).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       scl,
    inout  wire        sda,
    input  logic       msb_lsb,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       addressed,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [3:0] FL_TOP = 4'(FILTER_LEN - 1);

    state_t     state;
    state_t     state_nxt;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic [3:0] scl_cnt;
    logic [3:0] sda_cnt;
    logic       scl_f;
    logic       sda_f;
    logic       scl_d;
    logic       sda_d;

    logic       scl_rise;
    logic       scl_fall;
    logic       start_ev;
    logic       stop_ev;

    logic [2:0] cnt;
    logic [7:0] sh;
    logic [7:0] sh_in;
    logic       phase;
    logic       sda_oe;
    logic       msb_eff;
    logic       addr_match;
    logic       tx_bit;
    logic       tx_first;

    logic       shift_en;
    logic       cnt_load;
    logic       cnt_dec;
    logic       phase_set;
    logic       phase_clr;
    logic       oe_nxt;
    logic       tx_ld;
    logic       rx_done;
    logic       addr_set;
    logic       addr_clr;
    logic       rw_upd;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronizers; the bus idles high.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

    // SCL stability filter: level must hold FILTER_LEN samples.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_f   <= 1'b1;
            scl_cnt <= '0;
        end else if (scl_sync[1] == scl_f) begin
            scl_cnt <= '0;
        end else if (scl_cnt == FL_TOP) begin
            scl_f   <= scl_sync[1];
            scl_cnt <= '0;
        end else begin
            scl_cnt <= scl_cnt + 4'd1;
        end
    end

    // SDA stability filter, same rule as SCL.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sda_f   <= 1'b1;
            sda_cnt <= '0;
        end else if (sda_sync[1] == sda_f) begin
            sda_cnt <= '0;
        end else if (sda_cnt == FL_TOP) begin
            sda_f   <= sda_sync[1];
            sda_cnt <= '0;
        end else begin
            sda_cnt <= sda_cnt + 4'd1;
        end
    end

    // Previous filtered levels for edge detection.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

    // The address byte is always MSB first.
    assign msb_eff    = msb_lsb | (state == ADDR);
    assign sh_in      = msb_eff ? {sh[6:0], sda_f} : {sda_f, sh[7:1]};
    assign addr_match = (sh_in[7:1] == SLAVE_ADDR);
    assign tx_bit     = msb_lsb ? sh[cnt] : sh[~cnt];
    assign tx_first   = msb_lsb ? tx_data[7] : tx_data[0];

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; bus conditions override bit processing.
    always_comb begin
        state_nxt = state;
        if (stop_ev) begin
            state_nxt = IDLE;
        end else if (start_ev) begin
            state_nxt = ADDR;
        end else begin
            unique case (state)
                ADDR:
                    if (scl_rise && cnt == 3'd0)
                        state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:
                    if (scl_fall && phase)
                        state_nxt = rw ? TX_BYTE : RX_BYTE;
                RX_BYTE:
                    if (scl_rise && cnt == 3'd0)
                        state_nxt = RX_ACK;
                RX_ACK:
                    if (scl_fall && phase)
                        state_nxt = RX_BYTE;
                TX_BYTE:
                    if (scl_fall && phase)
                        state_nxt = TX_ACK;
                TX_ACK:
                    if (scl_rise && sda_f)
                        state_nxt = WAIT_STOP;
                    else if (scl_fall && phase)
                        state_nxt = TX_BYTE;
                default: ;
            endcase
        end
    end

    // Control decode; phase marks the second half of an ACK slot
    // or that the last TX bit has been clocked.
    always_comb begin
        shift_en  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        phase_set = 1'b0;
        phase_clr = 1'b0;
        oe_nxt    = sda_oe;
        tx_ld     = 1'b0;
        rx_done   = 1'b0;
        addr_set  = 1'b0;
        addr_clr  = 1'b0;
        rw_upd    = 1'b0;
        if (start_ev || stop_ev) begin
            oe_nxt    = 1'b0;
            addr_clr  = 1'b1;
            cnt_load  = 1'b1;
            phase_clr = 1'b1;
        end else begin
            unique case (state)
                ADDR:
                    if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_dec  = 1'b1;
                        if (cnt == 3'd0 && addr_match) begin
                            addr_set  = 1'b1;
                            rw_upd    = 1'b1;
                            phase_clr = 1'b1;
                        end
                    end
                ADDR_ACK, RX_ACK:
                    if (scl_fall) begin
                        if (!phase) begin
                            oe_nxt    = 1'b1;
                            phase_set = 1'b1;
                        end else begin
                            phase_clr = 1'b1;
                            cnt_load  = 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                tx_ld  = 1'b1;
                                oe_nxt = ~tx_first;
                            end else begin
                                oe_nxt = 1'b0;
                            end
                        end
                    end
                RX_BYTE:
                    if (scl_rise) begin
                        shift_en = 1'b1;
                        cnt_dec  = 1'b1;
                        if (cnt == 3'd0) rx_done = 1'b1;
                    end
                TX_BYTE:
                    if (scl_rise) begin
                        if (cnt == 3'd0) phase_set = 1'b1;
                        else             cnt_dec   = 1'b1;
                    end else if (scl_fall) begin
                        if (phase) begin
                            oe_nxt    = 1'b0;
                            phase_clr = 1'b1;
                        end else begin
                            oe_nxt = ~tx_bit;
                        end
                    end
                TX_ACK:
                    if (scl_rise) begin
                        if (sda_f) addr_clr  = 1'b1;
                        else       phase_set = 1'b1;
                    end else if (scl_fall && phase) begin
                        tx_ld     = 1'b1;
                        cnt_load  = 1'b1;
                        phase_clr = 1'b1;
                        oe_nxt    = ~tx_first;
                    end
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt       <= 3'd7;
            sh        <= '0;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid  <= rx_done;
            tx_load   <= tx_ld;
            start_det <= start_ev;
            stop_det  <= stop_ev;
            sda_oe    <= oe_nxt;
            if (cnt_load)     cnt <= 3'd7;
            else if (cnt_dec) cnt <= cnt - 3'd1;
            if (phase_clr)      phase <= 1'b0;
            else if (phase_set) phase <= 1'b1;
            if (tx_ld)         sh <= tx_data;
            else if (shift_en) sh <= sh_in;
            if (rx_done) rx_data <= sh_in;
            if (rw_upd)  rw <= sh_in[0];
            if (addr_clr)      addressed <= 1'b0;
            else if (addr_set) addressed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
// tb_i2c_slave: bus-level master driving directed transactions,
// with a transaction model and a per-cycle output checker.
module tb_i2c_slave;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_low = 1'b0;
    logic       msb_lsb = 1'b1;
    logic       allow = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       addressed;
    logic       rw;
    logic       start_det;
    logic       stop_det;
    wire        sda;

    int nvec = 0;
    int nerr = 0;
    int n_start = 0, n_stop = 0, n_rx = 0, n_tx = 0, n_drv = 0;
    int rx_wr = 0, rx_rd = 0, tx_wr = 0, tx_rd = 0;
    logic [7:0] exp_rx [0:31];
    logic [7:0] tx_list [0:31];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup pu (sda);
    assign tx_data = tx_list[tx_rd];

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h42), .FILTER_LEN(3)) dut (
        .clk(clk), .arstn(arstn), .scl(m_scl), .sda(sda),
        .msb_lsb(msb_lsb), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .addressed(addressed),
        .rw(rw), .start_det(start_det), .stop_det(stop_det)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Per-cycle checker against the transaction model.
    always @(negedge clk) begin
        if (arstn) begin
            if (start_det) n_start++;
            if (stop_det) n_stop++;
            if (tx_load) begin
                n_tx++;
                tx_rd++;
            end
            if (rx_valid) begin
                n_rx++;
                if (rx_rd < rx_wr) begin
                    chk("rx_data", int'(rx_data), int'(exp_rx[rx_rd]));
                    rx_rd++;
                end else begin
                    chk("rx_valid_unexpected", int'(rx_valid), 0);
                end
            end
            if (sda === 1'b0 && !m_low) begin
                n_drv++;
                chk("sda_drive_window", int'(allow), 1);
            end
        end
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        wq(Q);
        m_low = ~b;
        wq(Q);
        m_scl = 1'b1;
        wq(Q);
        s = sda;
        wq(Q);
        m_scl = 1'b0;
    endtask

    task automatic start_c();
        m_low = 1'b1;
        wq(Q);
        m_scl = 1'b0;
    endtask

    task automatic rstart_c();
        wq(Q);
        m_low = 1'b0;
        wq(Q);
        m_scl = 1'b1;
        wq(Q);
        m_low = 1'b1;
        wq(Q);
        m_scl = 1'b0;
    endtask

    task automatic stop_c();
        wq(Q);
        m_low = 1'b1;
        wq(Q);
        m_scl = 1'b1;
        wq(Q);
        m_low = 1'b0;
        wq(2 * Q);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_list[tx_wr] = b;
        tx_wr++;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic acks,
                           input logic data, input string nm);
        logic s;
        if (acks && data) begin
            exp_rx[rx_wr] = msb_lsb ? b : rev8(b);
            rx_wr++;
        end
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        allow = acks;
        bus_bit(1'b1, s);
        chk({nm, "_ack"}, int'(s), acks ? 0 : 1);
        wq(10);
        if (!(acks && !data && b[0])) allow = 1'b0;
    endtask

    task automatic rd_byte(input logic mack, input logic [7:0] tx,
                           input string nm, output logic [7:0] got);
        logic s;
        got = '0;
        allow = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            got[i] = s;
        end
        wq(10);
        allow = 1'b0;
        bus_bit(mack, s);
        chk({nm, "_bus"}, int'(got), int'(msb_lsb ? tx : rev8(tx)));
    endtask

    initial begin
        int s0, p0, r0, t0, d0, lat;
        logic [7:0] got;

        for (int i = 0; i < 32; i++) tx_list[i] = 8'h00;
        wq(4);
        chk("rst_sda", int'(sda), 1);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_outs", int'({rx_valid, tx_load, addressed, rw,
                              start_det, stop_det}), 0);
        arstn = 1'b1;
        wq(10);

        // Write 0x84, 0xA5, 0x3C, STOP.
        s0 = n_start; p0 = n_stop; r0 = n_rx;
        lat = 0;
        m_low = 1'b1;
        for (int n = 1; n <= Q; n++) begin
            @(posedge clk);
            #1;
            if (start_det && lat == 0) lat = n;
        end
        m_scl = 1'b0;
        chk("start_latency", lat, 6);
        wr_byte(8'h84, 1'b1, 1'b0, "w_addr");
        chk("w_addressed", int'(addressed), 1);
        chk("w_rw", int'(rw), 0);
        wr_byte(8'hA5, 1'b1, 1'b1, "w_d0");
        wr_byte(8'h3C, 1'b1, 1'b1, "w_d1");
        stop_c();
        chk("w_rx_count", n_rx - r0, 2);
        chk("w_rx_last", int'(rx_data), 8'h3C);
        chk("w_start_count", n_start - s0, 1);
        chk("w_stop_count", n_stop - p0, 1);
        chk("w_addressed_end", int'(addressed), 0);

        // Read 0x85: 0x5A with ACK, 0xC3 with NACK.
        s0 = n_start; t0 = n_tx;
        push_tx(8'h5A);
        push_tx(8'hC3);
        start_c();
        wr_byte(8'h85, 1'b1, 1'b0, "r_addr");
        chk("r_rw", int'(rw), 1);
        rd_byte(1'b0, 8'h5A, "r_d0", got);
        chk("r_d0_literal", int'(got), 8'h5A);
        rd_byte(1'b1, 8'hC3, "r_d1", got);
        chk("r_d1_literal", int'(got), 8'hC3);
        chk("r_addressed_nack", int'(addressed), 0);
        stop_c();
        chk("r_tx_count", n_tx - t0, 2);
        chk("r_start_count", n_start - s0, 1);

        // Address mismatch 0x90 with two data bytes.
        s0 = n_start; p0 = n_stop; r0 = n_rx; t0 = n_tx; d0 = n_drv;
        start_c();
        wr_byte(8'h90, 1'b0, 1'b0, "m_addr");
        wr_byte(8'h12, 1'b0, 1'b1, "m_d0");
        wr_byte(8'h34, 1'b0, 1'b1, "m_d1");
        stop_c();
        chk("m_drive_cycles", n_drv - d0, 0);
        chk("m_rx_count", n_rx - r0, 0);
        chk("m_tx_count", n_tx - t0, 0);
        chk("m_start_count", n_start - s0, 1);
        chk("m_stop_count", n_stop - p0, 1);

        // Write 0x11, repeated START, read 0x77 with NACK.
        s0 = n_start; r0 = n_rx; t0 = n_tx;
        push_tx(8'h77);
        start_c();
        wr_byte(8'h84, 1'b1, 1'b0, "rs_waddr");
        chk("rs_rw0", int'(rw), 0);
        wr_byte(8'h11, 1'b1, 1'b1, "rs_wd");
        rstart_c();
        wr_byte(8'h85, 1'b1, 1'b0, "rs_raddr");
        chk("rs_rw1", int'(rw), 1);
        rd_byte(1'b1, 8'h77, "rs_rd", got);
        chk("rs_rd_literal", int'(got), 8'h77);
        stop_c();
        chk("rs_rx_count", n_rx - r0, 1);
        chk("rs_rx_literal", int'(rx_data), 8'h11);
        chk("rs_start_count", n_start - s0, 2);
        chk("rs_tx_count", n_tx - t0, 1);

        // Bit order on data bytes.
        msb_lsb = 1'b0;
        start_c();
        wr_byte(8'h84, 1'b1, 1'b0, "lsb_addr");
        wr_byte(8'h80, 1'b1, 1'b1, "lsb_d");
        stop_c();
        chk("lsb_rx_literal", int'(rx_data), 8'h01);
        msb_lsb = 1'b1;
        start_c();
        wr_byte(8'h84, 1'b1, 1'b0, "msb_addr");
        wr_byte(8'h80, 1'b1, 1'b1, "msb_d");
        stop_c();
        chk("msb_rx_literal", int'(rx_data), 8'h80);

        // Single-clk SDA glitches while SCL is high.
        s0 = n_start; p0 = n_stop;
        m_low = 1'b1;
        wq(1);
        m_low = 1'b0;
        wq(Q);
        chk("glitch_no_start", n_start - s0, 0);
        m_low = 1'b1;
        wq(Q);
        m_low = 1'b0;
        wq(1);
        m_low = 1'b1;
        wq(Q);
        chk("glitch_one_start", n_start - s0, 1);
        chk("glitch_no_stop", n_stop - p0, 0);
        m_scl = 1'b0;
        stop_c();
        chk("glitch_real_stop", n_stop - p0, 1);

        // Asynchronous reset in the middle of the address ACK.
        start_c();
        for (int i = 7; i >= 0; i--) begin
            logic s;
            logic [7:0] a;
            a = 8'h84;
            bus_bit(a[i], s);
        end
        allow = 1'b1;
        wq(Q);
        m_low = 1'b0;
        wq(Q);
        m_scl = 1'b1;
        wq(Q / 2);
        chk("rst_ack_driven", int'(sda), 0);
        #2;
        arstn = 1'b0;
        #1;
        chk("rst_mid_sda", int'(sda), 1);
        chk("rst_mid_rx_data", int'(rx_data), 0);
        chk("rst_mid_outs", int'({rx_valid, tx_load, addressed, rw,
                                  start_det, stop_det}), 0);
        wq(2);
        arstn = 1'b1;
        allow = 1'b0;
        wq(5);
        m_scl = 1'b0;
        stop_c();
        chk("post_rst_addressed", int'(addressed), 0);
        chk("rx_all_seen", rx_rd, rx_wr);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
